rvc_fetch_aligner: RTL and testbench
====================================

Name: rvc_fetch_aligner

Overview:
- Realignment buffer between the instruction-fetch port and the decode stage of the RV32IC core.
- Accepts word-aligned 32-bit fetch words and stores them as 16-bit parcels in a circular FIFO.
- Emits one whole instruction per handshake: 16-bit compressed, or 32-bit (which may straddle two fetch words), together with its PC.
- Handles redirects (flush to any halfword-aligned PC) and, optionally, expands compressed instructions inline.

Parameters:
- DEPTH, 8, FIFO capacity in 16-bit parcels; power of two, minimum 4.
- RESET_VECTOR, 32'h0000_0000, PC of first instruction after reset; bit 0 ignored.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush_i  input  1  redirect: discard all buffered parcels.
- flush_pc_i  input  32  new PC on flush; bit 0 ignored.
- fetch_valid_i  input  1  fetch word available.
- fetch_ready_o  output  1  aligner can accept a fetch word.
- fetch_data_i  input  32  fetch word; [15:0] is the lower-address parcel.
- instr_valid_o  output  1  complete instruction at the FIFO head.
- instr_ready_i  input  1  decode consumes the instruction.
- instr_o  output  32  instruction bits.
- instr_pc_o  output  32  PC of instr_o.
- instr_compressed_o  output  1  head parcel[1:0] != 2'b11.
- instr_illegal_o  output  1  illegal compressed encoding (see Optional Feature).

Behaviour:
- State:
  - parcel array DEPTH x 16
  - rd_ptr, wr_ptr: $clog2(DEPTH) bits each, wrap modulo DEPTH
  - count: $clog2(DEPTH)+1 bits
  - pc_q: 32 bits
  - skip_q: 1 bit, drop the lower parcel of the next accepted word
- Reset (async, rst_n=0): pointers 0, count 0, pc_q = {RESET_VECTOR[31:1],1'b0}, skip_q = RESET_VECTOR[1].
  - Resulting outputs: instr_valid_o=0, fetch_ready_o=1, instr_pc_o = pc_q.
  - Reset asserted mid-transfer discards all content.
- fetch_ready_o = (DEPTH - count >= 2), combinational from registered count. It does not depend on same-cycle pop.
- Push (fetch_valid_i & fetch_ready_o & !flush_i):
  - skip_q=0: write [15:0] then [31:16], wr_ptr += 2.
  - skip_q=1: write [31:16] only, wr_ptr += 1, then clear skip_q.
- Head decode (combinational from FIFO head, no added latency):
  - h0 = parcel[rd_ptr], h1 = parcel[rd_ptr+1] (index wraps).
  - instr_compressed_o = (h0[1:0] != 2'b11).
  - instr_valid_o = count>=1 & compressed, or count>=2 & !compressed.
  - instr_o = {h1,h0} for 32-bit instructions.
  - A lone upper half of a 32-bit instruction is never presented.
- Pop (instr_valid_o & instr_ready_i & !flush_i):
  - rd_ptr and count decrease by 1 (compressed) or 2 (32-bit).
  - pc_q += 2 or 4, modulo 2^32.
- Simultaneous push and pop: count_next = count + pushed - popped, pushed ∈ {0,1,2}, popped ∈ {0,1,2}. Never overflows, because of the ready rule.
- Latency: word accepted in cycle N is visible on instr_* in cycle N+1. A 32-bit instruction straddling words becomes valid the cycle after its second word is accepted.
- instr_valid_o may be high with instr_ready_i low. The head must then hold stable (instr_o, instr_pc_o, flags) until popped or flushed.
- Flush has priority over push and pop in the same cycle; that cycle's fetch word and pop are discarded. Next cycle:
  - count=0, rd_ptr=wr_ptr=0
  - pc_q = {flush_pc_i[31:1],1'b0}, skip_q = flush_pc_i[1]
  - instr_valid_o=0
- Back-to-back flushes: the last one wins.
- Full (count = DEPTH-1 or DEPTH): fetch_ready_o=0.
- Empty: instr_valid_o=0; instr_o and flags are don't-care except instr_pc_o = pc_q.

Optional Feature:
- Macro: RVC_EXPAND_EN.
- Defined:
  - A compressed head is expanded combinationally to its RV32I equivalent per the RV32C spec: quadrants C0/C1/C2, including c.addi16sp, c.lui, c.ebreak, c.jalr.
  - instr_illegal_o=1 for reserved/illegal encodings: c.addi4spn with zero imm; c.lui/c.addi16sp with zero imm; shift with bit12=1; c.lwsp rd=0; c.jr rs1=0; RV64/FP opcodes.
  - instr_illegal_o is gated by instr_valid_o.
  - 32-bit instructions pass unchanged with illegal=0.
- Not defined:
  - instr_o = {16'h0000, h0} for compressed heads.
  - instr_illegal_o tied 0; expansion logic is absent.
  - Downstream decode handles compressed encodings.

Test Plan:
- Reset with RESET_VECTOR=0; push 32'h00A00093 and 32'h00000013 -> two 32-bit pops, PC 0 then 4; instr_compressed_o=0.
- Push 32'h0505_4501 (c.li a0,0 then c.addi a0,1) -> two pops, PC 0 then 2.
  - Expansion on: instr_o 32'h00000513 then 32'h00150513.
  - Expansion off: instr_o 32'h00004501 then 32'h00000505.
- Straddle: push 32'h0093_4501, then 32'h1234_00A0 -> c.li at PC 0, then 32'h00A00093 at PC 2, valid the cycle after the second push; upper parcel 16'h1234 remains at PC 6.
- Flush to 32'h0000_0102, then push 32'h4585_FFFF -> lower parcel dropped; single pop of 16'h4585 (c.li a1,1) at PC 0x102.
- Hold instr_ready_i=0 with DEPTH=8 and pushes every cycle -> fetch_ready_o drops at count>=7, no overwrite; head stable. Release ready -> all parcels drain in order with contiguous PCs.
- Flush, fetch_valid_i and instr_ready_i all high in the same cycle -> next cycle count=0, instr_valid_o=0, pc=flush_pc_i; the same-cycle word is not stored.
- Expansion-on case: push 32'h0000_0000 -> instr_valid_o=1, instr_illegal_o=1 (zero-imm c.addi4spn).

Source files
------------

// File: rtl/rvc_fetch_aligner_if.sv
// ============================================================================
//  Module      : rvc_fetch_aligner_if
//  Description : Fetch-side and decode-side handshake bundle for the
//                RV32IC fetch aligner, including the redirect request.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rvc_fetch_aligner_if;
  // Redirect
  logic        flush_i;
  logic [31:0] flush_pc_i;
  // Fetch side
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  // Decode side
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_illegal_o;

  // Fetch unit / decode stage / redirect source
  modport master (
    output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, instr_ready_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_pc_o,
           instr_compressed_o, instr_illegal_o
  );

  // The aligner itself
  modport slave (
    input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, instr_ready_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_pc_o,
           instr_compressed_o, instr_illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/rvc_fetch_aligner.sv
// ============================================================================
//  Module      : rvc_fetch_aligner
//  Description : Realignment buffer between instruction fetch and decode.
//                Stores 32-bit fetch words as 16-bit parcels in a circular
//                FIFO and presents one whole (16- or 32-bit) instruction with
//                its PC per handshake. Optional macro RVC_EXPAND_EN expands
//                compressed instructions to RV32I and flags illegal encodings.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvc_fetch_aligner #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  rvc_fetch_aligner_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic          skip_q, skip_d;

  logic [AW-1:0] rd_ptr_nx;
  logic [AW-1:0] wr_ptr_nx;
  logic [15:0]   h0, h1;
  logic          head_comp;
  logic          head_valid;
  logic          fetch_ready;
  logic          push, pop;
  logic [1:0]    n_push, n_pop;
  logic          unused_pc_bit;

  // Head parcels; the second index wraps naturally at AW bits.
  assign rd_ptr_nx  = rd_ptr_q + AW'(1);
  assign wr_ptr_nx  = wr_ptr_q + AW'(1);
  assign h0         = mem_q[rd_ptr_q];
  assign h1         = mem_q[rd_ptr_nx];
  assign head_comp  = (h0[1:0] != 2'b11);
  // A 32-bit instruction needs both parcels before it is presented.
  assign head_valid = ((count_q >= CW'(1)) && head_comp) ||
                      ((count_q >= CW'(2)) && !head_comp);
  // Room for a full word, independent of a same-cycle pop.
  assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);

  assign push   = bus.fetch_valid_i && fetch_ready && !bus.flush_i;
  assign pop    = head_valid && bus.instr_ready_i && !bus.flush_i;
  assign n_push = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign n_pop  = pop ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

  assign unused_pc_bit = bus.flush_pc_i[0];

  // Parcel writes: the lower half is dropped when entering mid-word.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      if (skip_q) begin
        mem_d[wr_ptr_q] = bus.fetch_data_i[31:16];
      end else begin
        mem_d[wr_ptr_q]  = bus.fetch_data_i[15:0];
        mem_d[wr_ptr_nx] = bus.fetch_data_i[31:16];
      end
    end
  end

  // Pointer, occupancy and PC bookkeeping; a redirect overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    skip_d   = skip_q;
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = {bus.flush_pc_i[31:1], 1'b0};
      skip_d   = bus.flush_pc_i[1];
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(n_pop);
        pc_d     = pc_q + (head_comp ? 32'd2 : 32'd4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(n_push);
        skip_d   = 1'b0;
      end
      count_d = count_q + CW'(n_push) - CW'(n_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= {RESET_VECTOR[31:1], 1'b0};
      skip_q   <= RESET_VECTOR[1];
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      skip_q   <= skip_d;
    end
  end

  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_mem
    // Parcel storage entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  assign bus.fetch_ready_o      = fetch_ready;
  assign bus.instr_valid_o      = head_valid;
  assign bus.instr_pc_o         = pc_q;
  assign bus.instr_compressed_o = head_comp;

`ifdef RVC_EXPAND_EN
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [4:0]  rdp, rs1p, rd, rs2;
  logic [11:0] imm6_sx;
  logic [20:0] j_imm;
  logic [12:0] b_imm;
  logic [31:0] x_instr;
  logic        x_illegal;

  assign rdp     = {2'b01, h0[4:2]};
  assign rs1p    = {2'b01, h0[9:7]};
  assign rd      = h0[11:7];
  assign rs2     = h0[6:2];
  assign imm6_sx = {{7{h0[12]}}, h0[6:2]};
  assign j_imm   = {{10{h0[12]}}, h0[8], h0[10:9], h0[6], h0[7], h0[2],
                    h0[11], h0[5:3], 1'b0};
  assign b_imm   = {{5{h0[12]}}, h0[6:5], h0[2], h0[11:10], h0[4:3], 1'b0};

  // RV32C to RV32I expansion of the head parcel.
  always_comb begin
    x_instr   = {h1, h0};
    x_illegal = 1'b0;
    case (h0[1:0])
      2'b00: begin
        case (h0[15:13])
          3'b000: begin  // c.addi4spn
            x_instr   = {2'b00, h0[10:7], h0[12:11], h0[5], h0[6], 2'b00,
                         5'd2, 3'b000, rdp, OP_IMM};
            x_illegal = (h0[12:5] == 8'h00);
          end
          3'b010: x_instr = {5'b0, h0[5], h0[12:10], h0[6], 2'b00,
                             rs1p, 3'b010, rdp, OP_LD};            // c.lw
          3'b110: x_instr = {5'b0, h0[5], h0[12], rdp, rs1p, 3'b010,
                             h0[11:10], h0[6], 2'b00, OP_ST};      // c.sw
          default: x_illegal = 1'b1;                               // FP / reserved
        endcase
      end
      2'b01: begin
        case (h0[15:13])
          3'b000: x_instr = {imm6_sx, rd, 3'b000, rd, OP_IMM};     // c.addi
          3'b001: x_instr = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12],
                             5'd1, OP_JAL};                        // c.jal
          3'b010: x_instr = {imm6_sx, 5'd0, 3'b000, rd, OP_IMM};   // c.li
          3'b011: begin
            x_illegal = ({h0[12], h0[6:2]} == 6'd0);
            if (rd == 5'd2) begin                                  // c.addi16sp
              x_instr = {{3{h0[12]}}, h0[4:3], h0[5], h0[2], h0[6], 4'b0000,
                         5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin                                         // c.lui
              x_instr = {{15{h0[12]}}, h0[6:2], rd, OP_LUI};
            end
          end
          3'b100: begin
            case (h0[11:10])
              2'b00: begin
                x_instr   = {7'b0000000, h0[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                x_illegal = h0[12];
              end
              2'b01: begin
                x_instr   = {7'b0100000, h0[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                x_illegal = h0[12];
              end
              2'b10: x_instr = {imm6_sx, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                x_illegal = h0[12];                                // subw/addw
                case (h0[6:5])
                  2'b00:   x_instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                  2'b01:   x_instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                  2'b10:   x_instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                  default: x_instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                endcase
              end
            endcase
          end
          3'b101: x_instr = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12],
                             5'd0, OP_JAL};                        // c.j
          3'b110: x_instr = {b_imm[12], b_imm[10:5], 5'd0, rs1p, 3'b000,
                             b_imm[4:1], b_imm[11], OP_BR};        // c.beqz
          default: x_instr = {b_imm[12], b_imm[10:5], 5'd0, rs1p, 3'b001,
                              b_imm[4:1], b_imm[11], OP_BR};       // c.bnez
        endcase
      end
      2'b10: begin
        case (h0[15:13])
          3'b000: begin                                            // c.slli
            x_instr   = {7'b0000000, h0[6:2], rd, 3'b001, rd, OP_IMM};
            x_illegal = h0[12];
          end
          3'b010: begin                                            // c.lwsp
            x_instr   = {4'b0000, h0[3:2], h0[12], h0[6:4], 2'b00,
                         5'd2, 3'b010, rd, OP_LD};
            x_illegal = (rd == 5'd0);
          end
          3'b100: begin
            if (!h0[12]) begin
              if (rs2 == 5'd0) begin                               // c.jr
                x_instr   = {12'h000, rd, 3'b000, 5'd0, OP_JR};
                x_illegal = (rd == 5'd0);
              end else begin                                       // c.mv
                x_instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
              end
            end else if (rs2 == 5'd0 && rd == 5'd0) begin          // c.ebreak
              x_instr = 32'h0010_0073;
            end else if (rs2 == 5'd0) begin                        // c.jalr
              x_instr = {12'h000, rd, 3'b000, 5'd1, OP_JR};
            end else begin                                         // c.add
              x_instr = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
            end
          end
          3'b110: x_instr = {4'b0000, h0[8:7], h0[12], rs2, 5'd2, 3'b010,
                             h0[11:9], 2'b00, OP_ST};              // c.swsp
          default: x_illegal = 1'b1;                               // FP / RV64
        endcase
      end
      default: begin
        x_instr   = {h1, h0};
        x_illegal = 1'b0;
      end
    endcase
  end

  assign bus.instr_o         = head_comp ? x_instr : {h1, h0};
  assign bus.instr_illegal_o = head_valid && head_comp && x_illegal;
`else
  assign bus.instr_o         = head_comp ? {16'h0000, h0} : {h1, h0};
  assign bus.instr_illegal_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvc_fetch_aligner.sv
// ============================================================================
//  Module      : tb_rvc_fetch_aligner
//  Description : Self-checking bench for rvc_fetch_aligner: parcel-queue
//                reference model, per-cycle comparison, directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rvc_fetch_aligner;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  rvc_fetch_aligner_if bus();

  rvc_fetch_aligner #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of parcels in program order plus head PC.
  logic [15:0] mq[$];
  logic [31:0] m_pc   = 32'h0;
  bit          m_skip = 1'b0;

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (mq[0][1:0] != 2'b11) return 1'b1;
    return mq.size() >= 2;
  endfunction

  function automatic bit m_ready();
    return (DEPTH - mq.size()) >= 2;
  endfunction

  task automatic model_step();
    bit v;
    bit r;
    if (!rst_n) begin
      mq.delete();
      m_pc   = {RV[31:1], 1'b0};
      m_skip = RV[1];
    end else if (bus.flush_i) begin
      mq.delete();
      m_pc   = {bus.flush_pc_i[31:1], 1'b0};
      m_skip = bus.flush_pc_i[1];
    end else begin
      v = m_valid();
      r = m_ready();
      if (v && bus.instr_ready_i) begin
        if (mq[0][1:0] != 2'b11) begin
          void'(mq.pop_front());
          m_pc = m_pc + 32'd2;
        end else begin
          void'(mq.pop_front());
          void'(mq.pop_front());
          m_pc = m_pc + 32'd4;
        end
      end
      if (bus.fetch_valid_i && r) begin
        if (!m_skip) mq.push_back(bus.fetch_data_i[15:0]);
        mq.push_back(bus.fetch_data_i[31:16]);
        m_skip = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    bit c;
    @(negedge clk);
    if (rst_n) begin
      chk("valid", bus.instr_valid_o, m_valid());
      chk("pc", bus.instr_pc_o, m_pc);
      chk("ready", bus.fetch_ready_o, m_ready());
      if (m_valid()) begin
        c = (mq[0][1:0] != 2'b11);
        chk("compressed", bus.instr_compressed_o, c);
`ifdef RVC_EXPAND_EN
        if (!c) begin
          chk("instr32", bus.instr_o, {mq[1], mq[0]});
          chk("illegal32", bus.instr_illegal_o, 0);
        end
`else
        chk("instr", bus.instr_o, c ? {16'h0000, mq[0]} : {mq[1], mq[0]});
        chk("illegal", bus.instr_illegal_o, 0);
`endif
      end else begin
        chk("illegal_idle", bus.instr_illegal_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit fv, input logic [31:0] d, input bit rdy);
    bus.fetch_valid_i = fv;
    bus.fetch_data_i  = d;
    bus.instr_ready_i = rdy;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = pc;
    tick();
    bus.flush_i    = 1'b0;
  endtask

  logic [31:0] words [5];
  int          idx;
  bit          acc;

  initial begin
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = 32'h0;
    set_in(1'b0, 32'h0, 1'b0);
    words[0] = 32'h4505_FFFF;
    words[1] = 32'h0093_4609;
    words[2] = 32'h4685_00A0;
    words[3] = 32'h0113_0001;
    words[4] = 32'h8082_0020;

    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", bus.instr_valid_o, 0);
    chk("rst_ready", bus.fetch_ready_o, 1);
    chk("rst_pc", bus.instr_pc_o, 32'h0);

    // Two 32-bit instructions
    set_in(1'b1, 32'h00A0_0093, 1'b0); tick();
    set_in(1'b1, 32'h0000_0013, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t1_valid", bus.instr_valid_o, 1);
    chk("t1_comp", bus.instr_compressed_o, 0);
    chk("t1_instr0", bus.instr_o, 32'h00A0_0093);
    chk("t1_pc0", bus.instr_pc_o, 32'h0);
    bus.instr_ready_i = 1'b1; tick();
    chk("t1_instr1", bus.instr_o, 32'h0000_0013);
    chk("t1_pc1", bus.instr_pc_o, 32'h4);
    tick();
    bus.instr_ready_i = 1'b0;
    chk("t1_empty", bus.instr_valid_o, 0);
    chk("t1_model_pc", m_pc, 32'h8);

    // Two compressed instructions in one word
    do_flush(32'h0);
    set_in(1'b1, 32'h0505_4501, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t2_comp", bus.instr_compressed_o, 1);
    chk("t2_pc0", bus.instr_pc_o, 32'h0);
`ifdef RVC_EXPAND_EN
    chk("t2_instr0", bus.instr_o, 32'h0000_0513);
`else
    chk("t2_instr0", bus.instr_o, 32'h0000_4501);
`endif
    bus.instr_ready_i = 1'b1; tick();
    chk("t2_pc1", bus.instr_pc_o, 32'h2);
`ifdef RVC_EXPAND_EN
    chk("t2_instr1", bus.instr_o, 32'h0015_0513);
`else
    chk("t2_instr1", bus.instr_o, 32'h0000_0505);
`endif
    tick();
    bus.instr_ready_i = 1'b0;
    chk("t2_empty", bus.instr_valid_o, 0);
    chk("t2_pc_end", bus.instr_pc_o, 32'h4);

    // 32-bit instruction straddling two fetch words
    do_flush(32'h0);
    set_in(1'b1, 32'h0093_4501, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b1); tick();
    chk("t3_half_hidden", bus.instr_valid_o, 0);
    chk("t3_half_pc", bus.instr_pc_o, 32'h2);
    set_in(1'b1, 32'h1234_00A0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t3_straddle_valid", bus.instr_valid_o, 1);
    chk("t3_straddle_instr", bus.instr_o, 32'h00A0_0093);
    chk("t3_straddle_pc", bus.instr_pc_o, 32'h2);
    bus.instr_ready_i = 1'b1; tick();
    bus.instr_ready_i = 1'b0;
    chk("t3_tail_pc", bus.instr_pc_o, 32'h6);
    chk("t3_tail_valid", bus.instr_valid_o, 1);
    chk("t3_model_tail", mq[0], 32'h1234);

    // Redirect to a halfword address: lower parcel dropped
    do_flush(32'h0000_0102);
    chk("t4_flush_pc", bus.instr_pc_o, 32'h102);
    chk("t4_flush_valid", bus.instr_valid_o, 0);
    set_in(1'b1, 32'h4585_FFFF, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t4_valid", bus.instr_valid_o, 1);
    chk("t4_pc", bus.instr_pc_o, 32'h102);
    chk("t4_model_count", mq.size(), 1);
`ifdef RVC_EXPAND_EN
    chk("t4_instr", bus.instr_o, 32'h0010_0593);
`else
    chk("t4_instr", bus.instr_o, 32'h0000_4585);
`endif
    bus.instr_ready_i = 1'b1; tick();
    bus.instr_ready_i = 1'b0;
    chk("t4_drained", bus.instr_valid_o, 0);
    chk("t4_pc_end", bus.instr_pc_o, 32'h104);

    // Back-pressure until full, then drain
    do_flush(32'h2);
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      set_in(idx < 5, (idx < 5) ? words[idx] : 32'h0, 1'b0);
      acc = bus.fetch_valid_i && bus.fetch_ready_o;
      tick();
      if (acc) idx++;
    end
    chk("t5_full_ready", bus.fetch_ready_o, 0);
    chk("t5_full_count", mq.size(), 7);
    chk("t5_head_pc", bus.instr_pc_o, 32'h2);
`ifdef RVC_EXPAND_EN
    chk("t5_head_instr", bus.instr_o, 32'h0010_0513);
`else
    chk("t5_head_instr", bus.instr_o, 32'h0000_4505);
`endif
    for (int cyc = 0; cyc < 14; cyc++) begin
      set_in(idx < 5, (idx < 5) ? words[idx] : 32'h0, 1'b1);
      acc = bus.fetch_valid_i && bus.fetch_ready_o;
      tick();
      if (acc) idx++;
    end
    set_in(1'b0, 32'h0, 1'b0);
    chk("t5_all_words", idx, 5);
    chk("t5_drain_pc", bus.instr_pc_o, 32'd20);
    chk("t5_drain_valid", bus.instr_valid_o, 0);

    // Flush with push and pop in the same cycle
    set_in(1'b1, 32'h00A0_0093, 1'b0); tick();
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h0000_0040;
    set_in(1'b1, 32'h4505_4501, 1'b1); tick();
    bus.flush_i = 1'b0;
    set_in(1'b0, 32'h0, 1'b0);
    chk("t6_valid", bus.instr_valid_o, 0);
    chk("t6_pc", bus.instr_pc_o, 32'h40);
    chk("t6_ready", bus.fetch_ready_o, 1);
    tick();
    chk("t6_still_empty", bus.instr_valid_o, 0);

    // All-zero parcel: reserved c.addi4spn encoding
    do_flush(32'h0);
    set_in(1'b1, 32'h0000_0000, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t7_valid", bus.instr_valid_o, 1);
    chk("t7_comp", bus.instr_compressed_o, 1);
`ifdef RVC_EXPAND_EN
    chk("t7_illegal", bus.instr_illegal_o, 1);
`else
    chk("t7_illegal", bus.instr_illegal_o, 0);
    chk("t7_instr", bus.instr_o, 32'h0);
`endif

    // Asynchronous reset with content buffered
    do_flush(32'h200);
    set_in(1'b1, 32'h00A0_0093, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0);
    chk("t8_pre_valid", bus.instr_valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_rst_valid", bus.instr_valid_o, 0);
    chk("t8_rst_pc", bus.instr_pc_o, 32'h0);
    chk("t8_rst_ready", bus.fetch_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
